// File: rtl/auth_pkg.sv
// Shared definitions for the user-ID login controller: state encoding,
// default parameter values and the ID width derivation.
package auth_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_GRANTED = 2'd2,
    S_LOCKED  = 2'd3
  } auth_state_e;

  localparam int unsigned DEF_DIGIT_W       = 4;
  localparam int unsigned DEF_DIGITS        = 4;
  localparam int unsigned DEF_ADDR_W        = 4;
  localparam int unsigned DEF_ENTRIES       = 16;
  localparam int unsigned DEF_MAX_TRIES     = 3;
  localparam int unsigned DEF_LOCK_CYCLES   = 1024;
  localparam int unsigned DEF_ENTRY_TIMEOUT = 0;

  function automatic int unsigned id_width(input int unsigned digit_w,
                                           input int unsigned digits);
    return digit_w * digits;
  endfunction

endpackage

// File: rtl/userid_auth_ctrl_if.sv
// Front-panel, ID ROM and access-gate signals of the login controller.
// master: environment / ROM side; slave: the controller.
interface userid_auth_ctrl_if
  import auth_pkg::*;
#(
  parameter int unsigned DIGIT_W = DEF_DIGIT_W,
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) ();
  localparam int unsigned ID_W = id_width(DIGIT_W, DIGITS);

  logic [DIGIT_W-1:0] in_toggle;
  logic               push_button;
  logic               logout;
  logic [ADDR_W-1:0]  rom_addr;
  logic [ID_W-1:0]    rom_data;
  logic [ADDR_W-1:0]  internalid;
  logic               access_rom;
  logic               busy;
  logic               fail;
  logic               locked;

  modport master (
    output in_toggle, push_button, logout, rom_data,
    input  rom_addr, internalid, access_rom, busy, fail, locked
  );

  modport slave (
    input  in_toggle, push_button, logout, rom_data,
    output rom_addr, internalid, access_rom, busy, fail, locked
  );
endinterface

// File: rtl/userid_entry_shift.sv
// Digit collector: shifts pushed digits into the entry register (first digit
// ends up most significant), counts them, and drops a stale partial entry.
module userid_entry_shift
  import auth_pkg::*;
#(
  parameter int unsigned DIGIT_W       = DEF_DIGIT_W,
  parameter int unsigned DIGITS        = DEF_DIGITS,
  parameter int unsigned ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   en_i,
  input  logic                                   clr_i,
  input  logic                                   push_i,
  input  logic [DIGIT_W-1:0]                     digit_i,
  output logic [id_width(DIGIT_W, DIGITS)-1:0]   entry_o,
  output logic                                   done_o
);
  localparam int unsigned ID_W    = id_width(DIGIT_W, DIGITS);
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
  localparam int unsigned TO_W    = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (ENTRY_TIMEOUT > 0) ? ENTRY_TIMEOUT - 1 : 0;
  localparam bit          TO_EN   = (ENTRY_TIMEOUT > 0);

  logic [ID_W-1:0]  entry_q, entry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic             accept, last, timeout;

  // clr_i (logout) has priority over a coincident push.
  assign accept  = en_i & push_i & ~clr_i;
  assign last    = (cnt_q == CNT_W'(DIGITS - 1));
  assign done_o  = accept & last;
  assign timeout = TO_EN && en_i && !push_i && (cnt_q != '0) && (idle_q == TO_W'(TO_LAST));
  assign entry_o = entry_q;

  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    if (clr_i || timeout) begin
      entry_d = '0;
      cnt_d   = '0;
      idle_d  = '0;
    end else if (accept) begin
      entry_d = (entry_q << DIGIT_W) | ID_W'(digit_i);
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      idle_d  = '0;
    end else if (TO_EN && en_i && (cnt_q != '0)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: rtl/userid_auth_ctrl.sv
// Login controller: collects a user ID, scans the synchronous ID ROM one address
// per cycle for the first match, grants access, and locks out after repeated failures.
module userid_auth_ctrl
  import auth_pkg::*;
#(
  parameter int unsigned DIGIT_W       = DEF_DIGIT_W,
  parameter int unsigned DIGITS        = DEF_DIGITS,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned ENTRIES       = DEF_ENTRIES,
  parameter int unsigned MAX_TRIES     = DEF_MAX_TRIES,
  parameter int unsigned LOCK_CYCLES   = DEF_LOCK_CYCLES,
  parameter int unsigned ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  userid_auth_ctrl_if.slave bus
);
  localparam int unsigned ID_W   = id_width(DIGIT_W, DIGITS);
  localparam int unsigned SCNT_W = $clog2(ENTRIES + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  auth_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] internalid_q, internalid_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              access_q, access_d;
  logic              fail_q, fail_d;
  logic [ID_W-1:0]   entry;
  logic              entry_done, entry_clr;

  userid_entry_shift #(
    .DIGIT_W      (DIGIT_W),
    .DIGITS       (DIGITS),
    .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) u_entry (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (state_q == S_IDLE),
    .clr_i  (entry_clr),
    .push_i (bus.push_button),
    .digit_i(bus.in_toggle),
    .entry_o(entry),
    .done_o (entry_done)
  );

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    internalid_d = internalid_q;
    scnt_d       = scnt_q;
    tries_d      = tries_q;
    lock_d       = lock_q;
    access_d     = access_q;
    fail_d       = 1'b0;
    entry_clr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.logout) begin
          entry_clr = 1'b1;
        end else if (entry_done) begin
          state_d    = S_SEARCH;
          rom_addr_d = '0;
          scnt_d     = '0;
        end
      end
      S_SEARCH: begin
        if (bus.logout) begin
          state_d   = S_IDLE;
          entry_clr = 1'b1;
        end else begin
          if (rom_addr_q != ADDR_W'(ENTRIES - 1)) rom_addr_d = rom_addr_q + 1'b1;
          scnt_d = scnt_q + 1'b1;
          // With scnt_q = n+1 the ROM word on rom_data belongs to address n.
          if (scnt_q != '0) begin
            if (bus.rom_data == entry) begin
              state_d      = S_GRANTED;
              access_d     = 1'b1;
              internalid_d = ADDR_W'(scnt_q - 1'b1);
              tries_d      = '0;
            end else if (scnt_q == SCNT_W'(ENTRIES)) begin
              fail_d    = 1'b1;
              entry_clr = 1'b1;
              tries_d   = tries_q + 1'b1;
              lock_d    = '0;
              state_d   = (tries_q == TRY_W'(MAX_TRIES - 1)) ? S_LOCKED : S_IDLE;
            end
          end
        end
      end
      S_GRANTED: begin
        if (bus.logout) begin
          state_d      = S_IDLE;
          access_d     = 1'b0;
          internalid_d = '0;
          entry_clr    = 1'b1;
        end
      end
      S_LOCKED: begin
        if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          tries_d = '0;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      internalid_q <= '0;
      scnt_q       <= '0;
      tries_q      <= '0;
      lock_q       <= '0;
      access_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      internalid_q <= internalid_d;
      scnt_q       <= scnt_d;
      tries_q      <= tries_d;
      lock_q       <= lock_d;
      access_q     <= access_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.internalid = internalid_q;
  assign bus.access_rom = access_q;
  assign bus.fail       = fail_q;
  assign bus.busy       = (state_q == S_SEARCH);
  assign bus.locked     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_userid_auth_ctrl.sv
// Directed bench for userid_auth_ctrl: default instance (a) plus an instance with
// an 8-cycle entry timeout (b), each with a behavioural 1-cycle-latency ID ROM.
module tb_userid_auth_ctrl;
  import auth_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  userid_auth_ctrl_if #(.DIGIT_W(4), .DIGITS(4), .ADDR_W(4)) a_if ();
  userid_auth_ctrl_if #(.DIGIT_W(4), .DIGITS(4), .ADDR_W(4)) b_if ();

  userid_auth_ctrl u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if.slave)
  );

  userid_auth_ctrl #(.ENTRY_TIMEOUT(8)) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (b_if.slave)
  );

  function automatic logic [15:0] rom_word(input logic [3:0] a);
    case (a)
      4'd5, 4'd9: return 16'hA3C1;
      4'd2:       return 16'hC1A3;
      default:    return 16'h5000 | {12'h000, a};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    a_if.rom_data <= rom_word(a_if.rom_addr);
    b_if.rom_data <= rom_word(b_if.rom_addr);
  end

  // {rom_addr[11:8], internalid[7:4], access[3], busy[2], fail[1], locked[0]}
  function automatic logic [11:0] outs(input bit b);
    if (b) return {b_if.rom_addr, b_if.internalid, b_if.access_rom, b_if.busy, b_if.fail,
                   b_if.locked};
    return {a_if.rom_addr, a_if.internalid, a_if.access_rom, a_if.busy, a_if.fail, a_if.locked};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit b, input logic push, input logic lo, input logic [3:0] d);
    if (b) begin
      b_if.push_button = push; b_if.logout = lo; b_if.in_toggle = d;
    end else begin
      a_if.push_button = push; a_if.logout = lo; a_if.in_toggle = d;
    end
  endtask

  task automatic push_digit(input bit b, input logic [3:0] d);
    drive(b, 1'b1, 1'b0, d);
    @(negedge clk);
    drive(b, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic push_id(input bit b, input logic [15:0] id);
    logic [15:0] v;
    v = id;
    for (int i = 3; i >= 0; i--) push_digit(b, v[i*4 +: 4]);
  endtask

  task automatic pulse_logout(input bit b);
    drive(b, 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    drive(b, 1'b0, 1'b0, 4'h0);
  endtask

  // Edges counted from the final-push edge until access_rom or fail shows.
  task automatic await_result(input bit b, output int lat, output bit granted);
    logic [11:0] o;
    lat = 0;
    granted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      o = outs(b);
      if (o[3]) begin
        granted = 1'b1;
        break;
      end
      if (o[1]) break;
    end
  endtask

  // A failed search returns one cycle after the fail edge (fail pulse width checked).
  task automatic search_expect(input bit b, input logic [15:0] id, input bit exp_grant,
                               input int exp_lat, input logic [3:0] exp_iid);
    logic [11:0] o;
    int          lat;
    bit          granted;
    push_id(b, id);
    o = outs(b);
    check_eq("busy_after_final_push", 32'(o[2]), 32'd1);
    check_eq("rom_addr_after_final_push", 32'(o[11:8]), 32'd0);
    await_result(b, lat, granted);
    check_eq("result_is_grant", 32'(granted), 32'(exp_grant));
    check_eq("result_latency", 32'(lat), 32'(exp_lat));
    o = outs(b);
    if (exp_grant) begin
      check_eq("internalid", 32'(o[7:4]), 32'(exp_iid));
      check_eq("busy_after_grant", 32'(o[2]), 32'd0);
    end else begin
      check_eq("rom_addr_saturated", 32'(o[11:8]), 32'd15);
      @(negedge clk);
      o = outs(b);
      check_eq("fail_single_cycle", 32'(o[1]), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] o;
    int          n;
    bit          flag;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0);
    drive(1, 1'b0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    check_eq("reset_outputs_a", 32'(outs(0)), 32'd0);
    check_eq("reset_outputs_b", 32'(outs(1)), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First match at address 5 (addr 9 holds the same ID): granted after E7.
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    push_digit(0, 4'h7);
    repeat (4) @(negedge clk);
    o = outs(0);
    check_eq("grant_held_access", 32'(o[3]), 32'd1);
    check_eq("grant_held_id_5", 32'(o[7:4]), 32'd5);
    check_eq("grant_push_ignored_busy", 32'(o[2]), 32'd0);

    pulse_logout(0);
    o = outs(0);
    check_eq("logout_access", 32'(o[3]), 32'd0);
    check_eq("logout_internalid", 32'(o[7:4]), 32'd0);
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);

    // Three wrong IDs lock the controller; fail surfaces at E(ENTRIES+1) = E17.
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("locked_after_fail1", 32'(outs(0) & 12'h001), 32'd0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("locked_after_fail2", 32'(outs(0) & 12'h001), 32'd0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("locked_after_fail3", 32'(outs(0) & 12'h001), 32'd1);
    // One lock cycle was already spent checking the fail pulse width.
    n = 0;
    flag = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      drive(0, i < 8, i == 10, 4'h1);
      @(negedge clk);
      n++;
      o = outs(0);
      if (o[2]) flag = 1'b1;
      if (!o[0]) break;
    end
    drive(0, 1'b0, 1'b0, 4'h0);
    check_eq("lock_remaining_cycles", 32'(n), 32'd1023);
    check_eq("lock_pushes_ignored", 32'(flag), 32'd0);
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);

    // Success clears the try counter.
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("no_lock_after_success", 32'(outs(0) & 12'h001), 32'd0);

    // Abort mid-search: no fail, no grant, tries stay at 1.
    push_id(0, 16'hA3C1);
    repeat (2) @(negedge clk);
    pulse_logout(0);
    check_eq("abort_busy", 32'(outs(0) & 12'h004), 32'd0);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      o = outs(0);
      if (o[1] || o[3]) flag = 1'b1;
    end
    check_eq("abort_no_fail_no_grant", 32'(flag), 32'd0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("abort_not_counted", 32'(outs(0) & 12'h001), 32'd0);
    search_expect(0, 16'h1111, 1'b0, 17, 4'd0);
    check_eq("lock_on_third_real_fail", 32'(outs(0) & 12'h001), 32'd1);

    // Reset during LOCKED.
    reset = 1'b1;
    #1;
    check_eq("reset_in_locked", 32'(outs(0)), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);

    // Reset during SEARCH.
    push_id(0, 16'hA3C1);
    @(negedge clk);
    check_eq("busy_before_reset", 32'(outs(0) & 12'h004), 32'h004);
    reset = 1'b1;
    #1;
    check_eq("reset_in_search", 32'(outs(0)), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Push and logout together: digit discarded, entry starts clean.
    drive(0, 1'b1, 1'b1, 4'hA);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0);
    check_eq("push_logout_no_search", 32'(outs(0) & 12'h004), 32'd0);
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);

    // Logout in IDLE discards a partial entry.
    push_digit(0, 4'hA);
    push_digit(0, 4'h3);
    pulse_logout(0);
    search_expect(0, 16'hA3C1, 1'b1, 7, 4'd5);
    pulse_logout(0);

    // Timeout instance: A,3 expire after 8 idle cycles, so C1A3 (addr 2) is searched.
    push_digit(1, 4'hA);
    push_digit(1, 4'h3);
    repeat (8) @(negedge clk);
    search_expect(1, 16'hC1A3, 1'b1, 4, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
